// File: rtl/mips_pipe_pkg.sv
// ---------------------------------------------------------------------------
// mips_pipe_pkg
// Shared definitions for the MIPS-style pipeline stages.
//   - Datapath and register-address widths, and the hard-wired zero register.
//   - Control bundle width and the bit position of every control signal
//     inside the bundle {RegWrite,MemtoReg,MemRead,MemWrite,Branch,RegDst,
//     ALUSrc,ALUOp[1:0]}.
//   - A small helper to pull MemRead out of a control bundle.
// No ports (package).
// ---------------------------------------------------------------------------
package mips_pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 9;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMTOREG = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_REGDST   = 3;
  localparam int CTRL_ALUSRC   = 2;
  localparam int CTRL_ALUOP_MSB = 1;
  localparam int CTRL_ALUOP_LSB = 0;

  typedef logic [CTRL_W-1:0] ctrl_t;

  function automatic logic ctrlMemRead(input ctrl_t ctrl);
    return ctrl[CTRL_MEMREAD];
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_if
// Bundles every non-clock/reset signal of the ID/EX stage.
//   master modport : the surrounding pipeline (drives ID/WB/Flush, sees EX side)
//   slave  modport : the id_ex_stage itself
// Signals:
//   Flush, ID_valid, ID_PC_plus4, ID_rs/rt/rd, ID_uses_rt, ID_imm,
//   ID_Read_data_1/2, ID_ctrl                  -> decode-side inputs
//   WB_RegWrite, WB_Write_register, WB_Write_data -> writeback port snoop
//   Stall                                      <- combinational stall request
//   EX_valid, EX_PC_plus4, EX_imm, EX_Read_data_1/2, EX_rs/rt/rd, EX_ctrl
//                                              <- registered EX-side copies
//   Bubble_count                               <- saturating bubble counter
// ---------------------------------------------------------------------------
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 16
);
  logic              Flush;
  logic              ID_valid;
  logic [DATA_W-1:0] ID_PC_plus4;
  logic [REG_AW-1:0] ID_rs;
  logic [REG_AW-1:0] ID_rt;
  logic [REG_AW-1:0] ID_rd;
  logic              ID_uses_rt;
  logic [DATA_W-1:0] ID_imm;
  logic [DATA_W-1:0] ID_Read_data_1;
  logic [DATA_W-1:0] ID_Read_data_2;
  logic [CTRL_W-1:0] ID_ctrl;
  logic              WB_RegWrite;
  logic [REG_AW-1:0] WB_Write_register;
  logic [DATA_W-1:0] WB_Write_data;

  logic              Stall;
  logic              EX_valid;
  logic [DATA_W-1:0] EX_PC_plus4;
  logic [DATA_W-1:0] EX_imm;
  logic [DATA_W-1:0] EX_Read_data_1;
  logic [DATA_W-1:0] EX_Read_data_2;
  logic [REG_AW-1:0] EX_rs;
  logic [REG_AW-1:0] EX_rt;
  logic [REG_AW-1:0] EX_rd;
  logic [CTRL_W-1:0] EX_ctrl;
  logic [CNT_W-1:0]  Bubble_count;

  modport master (
    output Flush, ID_valid, ID_PC_plus4, ID_rs, ID_rt, ID_rd, ID_uses_rt,
           ID_imm, ID_Read_data_1, ID_Read_data_2, ID_ctrl,
           WB_RegWrite, WB_Write_register, WB_Write_data,
    input  Stall, EX_valid, EX_PC_plus4, EX_imm, EX_Read_data_1,
           EX_Read_data_2, EX_rs, EX_rt, EX_rd, EX_ctrl, Bubble_count
  );

  modport slave (
    input  Flush, ID_valid, ID_PC_plus4, ID_rs, ID_rt, ID_rd, ID_uses_rt,
           ID_imm, ID_Read_data_1, ID_Read_data_2, ID_ctrl,
           WB_RegWrite, WB_Write_register, WB_Write_data,
    output Stall, EX_valid, EX_PC_plus4, EX_imm, EX_Read_data_1,
           EX_Read_data_2, EX_rs, EX_rt, EX_rd, EX_ctrl, Bubble_count
  );

endinterface

// File: rtl/id_ex_stage_hazard.sv
// ---------------------------------------------------------------------------
// hazard_detect_unit
// Purely combinational load-use hazard detector. Kept separate so the
// branch-in-ID logic can reuse it.
// Ports:
//   idValid_i   in  ID holds a real instruction
//   idRs_i      in  ID source register rs
//   idRt_i      in  ID register rt
//   idUsesRt_i  in  ID instruction reads rt as a source
//   exValid_i   in  EX holds a real instruction
//   exMemRead_i in  EX instruction is a load
//   exRt_i      in  EX load destination (rt)
//   hazard_o    out ID needs the load result before it exists
// ---------------------------------------------------------------------------
module hazard_detect_unit #(
  parameter int REG_AW = 5
) (
  input  logic              idValid_i,
  input  logic [REG_AW-1:0] idRs_i,
  input  logic [REG_AW-1:0] idRt_i,
  input  logic              idUsesRt_i,
  input  logic              exValid_i,
  input  logic              exMemRead_i,
  input  logic [REG_AW-1:0] exRt_i,
  output logic              hazard_o
);

  logic rsMatch;
  logic rtMatch;

  assign rsMatch = (exRt_i == idRs_i);
  assign rtMatch = idUsesRt_i && (exRt_i == idRt_i);

  // A load into r0 produces nothing anyone can depend on.
  assign hazard_o = idValid_i && exValid_i && exMemRead_i &&
                    (exRt_i != '0) && (rsMatch || rtMatch);

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use hazard detection. Loads every cycle
// (one-cycle latency, no handshake). A load-use hazard replaces the ID
// instruction with a bubble and raises Stall so upstream re-presents it;
// Flush squashes the ID instruction. Bubble_count saturates at all-ones and
// only counts hazard bubbles.
// Ports:
//   Clock    in  rising-edge clock
//   Reset_n  in  synchronous active-low reset
//   bus      id_ex_if.slave (ID/WB inputs, Flush, Stall and EX outputs)
// Configuration macro:
//   WB_BYPASS_EN  when defined, a same-cycle writeback to ID_rs/ID_rt (not r0)
//                 replaces the stale register-file read data on a normal load.
// ---------------------------------------------------------------------------
module id_ex_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic   Clock,
  input  logic   Reset_n,
  id_ex_if.slave bus
);

  logic              hazard;
  logic              squash;
  logic [DATA_W-1:0] readData1Normal;
  logic [DATA_W-1:0] readData2Normal;

  logic              exValid_d,  exValid_q;
  logic [DATA_W-1:0] exPcPlus4_d, exPcPlus4_q;
  logic [DATA_W-1:0] exImm_d,    exImm_q;
  logic [DATA_W-1:0] exRd1_d,    exRd1_q;
  logic [DATA_W-1:0] exRd2_d,    exRd2_q;
  logic [REG_AW-1:0] exRs_d,     exRs_q;
  logic [REG_AW-1:0] exRt_d,     exRt_q;
  logic [REG_AW-1:0] exRd_d,     exRd_q;
  logic [CTRL_W-1:0] exCtrl_d,   exCtrl_q;
  logic [CNT_W-1:0]  bubbleCnt_d, bubbleCnt_q;

  hazard_detect_unit #(
    .REG_AW(REG_AW)
  ) u_hazard (
    .idValid_i  (bus.ID_valid),
    .idRs_i     (bus.ID_rs),
    .idRt_i     (bus.ID_rt),
    .idUsesRt_i (bus.ID_uses_rt),
    .exValid_i  (exValid_q),
    .exMemRead_i(exCtrl_q[CTRL_MEMREAD]),
    .exRt_i     (exRt_q),
    .hazard_o   (hazard)
  );

  // Reset must drop Stall in the same cycle; Flush overrides the hazard
  // because the instruction being held is dead anyway.
  assign bus.Stall = hazard && !bus.Flush && Reset_n;
  assign squash    = bus.Flush || hazard;

`ifdef WB_BYPASS_EN
  // The register file writes on the same edge we sample, so its read ports
  // still show the old value when ID reads the register being written.
  logic wbHitRs;
  logic wbHitRt;

  assign wbHitRs = bus.WB_RegWrite && (bus.WB_Write_register != '0) &&
                   (bus.WB_Write_register == bus.ID_rs);
  assign wbHitRt = bus.WB_RegWrite && (bus.WB_Write_register != '0) &&
                   (bus.WB_Write_register == bus.ID_rt);

  assign readData1Normal = wbHitRs ? bus.WB_Write_data : bus.ID_Read_data_1;
  assign readData2Normal = wbHitRt ? bus.WB_Write_data : bus.ID_Read_data_2;
`else
  assign readData1Normal = bus.ID_Read_data_1;
  assign readData2Normal = bus.ID_Read_data_2;
`endif

  // Data fields always follow ID; only valid/ctrl (and the bypass) depend on
  // whether this cycle loads normally or inserts a bubble.
  always_comb begin
    exPcPlus4_d = bus.ID_PC_plus4;
    exImm_d     = bus.ID_imm;
    exRs_d      = bus.ID_rs;
    exRt_d      = bus.ID_rt;
    exRd_d      = bus.ID_rd;
    exValid_d   = bus.ID_valid;
    exCtrl_d    = bus.ID_valid ? bus.ID_ctrl : '0;
    exRd1_d     = readData1Normal;
    exRd2_d     = readData2Normal;
    bubbleCnt_d = bubbleCnt_q;

    if (squash) begin
      exValid_d = 1'b0;
      exCtrl_d  = '0;
      exRd1_d   = bus.ID_Read_data_1;
      exRd2_d   = bus.ID_Read_data_2;
    end

    // Only hazard bubbles count; a flush in the same cycle takes precedence.
    if (hazard && !bus.Flush && (bubbleCnt_q != {CNT_W{1'b1}})) begin
      bubbleCnt_d = bubbleCnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      exValid_q   <= 1'b0;
      exPcPlus4_q <= '0;
      exImm_q     <= '0;
      exRd1_q     <= '0;
      exRd2_q     <= '0;
      exRs_q      <= '0;
      exRt_q      <= '0;
      exRd_q      <= '0;
      exCtrl_q    <= '0;
      bubbleCnt_q <= '0;
    end else begin
      exValid_q   <= exValid_d;
      exPcPlus4_q <= exPcPlus4_d;
      exImm_q     <= exImm_d;
      exRd1_q     <= exRd1_d;
      exRd2_q     <= exRd2_d;
      exRs_q      <= exRs_d;
      exRt_q      <= exRt_d;
      exRd_q      <= exRd_d;
      exCtrl_q    <= exCtrl_d;
      bubbleCnt_q <= bubbleCnt_d;
    end
  end

  assign bus.EX_valid       = exValid_q;
  assign bus.EX_PC_plus4    = exPcPlus4_q;
  assign bus.EX_imm         = exImm_q;
  assign bus.EX_Read_data_1 = exRd1_q;
  assign bus.EX_Read_data_2 = exRd2_q;
  assign bus.EX_rs          = exRs_q;
  assign bus.EX_rt          = exRt_q;
  assign bus.EX_rd          = exRd_q;
  assign bus.EX_ctrl        = exCtrl_q;
  assign bus.Bubble_count   = bubbleCnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage built with a 4-bit bubble counter so
// saturation is reachable. A behavioural model of the EX-side contents is
// advanced every clock and compared with the DUT; directed scenarios add
// hand-computed literal expectations, then randomized traffic follows.
// Honours WB_BYPASS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;
  import mips_pipe_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [8:0] CTRL_ADD = 9'h10A;
  localparam logic [8:0] CTRL_LW  = 9'h1C4;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic rstN;

  id_ex_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(9), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CTRL_W(9), .CNT_W(CNT_W)) dut (
    .Clock  (clk),
    .Reset_n(rstN),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Behavioural picture of what EX should hold.
  bit        mValid;
  bit [8:0]  mCtrl;
  bit [31:0] mPc, mImm, mRd1, mRd2;
  bit [4:0]  mRs, mRt, mRd;
  int        mCnt;
  bit        lastStall;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit modelHazard();
    bit dep;
    dep = (mRt == bus.ID_rs) || (bus.ID_uses_rt && mRt == bus.ID_rt);
    return bus.ID_valid && mValid && mCtrl[6] && (mRt != 0) && dep;
  endfunction

  function automatic bit [31:0] readValue(input bit [4:0] r, input bit [31:0] rf);
    if (BYPASS && bus.WB_RegWrite && bus.WB_Write_register != 0 &&
        bus.WB_Write_register == r)
      return bus.WB_Write_data;
    return rf;
  endfunction

  task automatic modelUpdate();
    bit hz;
    if (!rstN) begin
      mValid = 0; mCtrl = 0; mPc = 0; mImm = 0; mRd1 = 0; mRd2 = 0;
      mRs = 0; mRt = 0; mRd = 0; mCnt = 0;
      return;
    end
    hz = modelHazard();
    if (bus.Flush || hz) begin
      mValid = 0;
      mCtrl  = 0;
      mRd1   = bus.ID_Read_data_1;
      mRd2   = bus.ID_Read_data_2;
      if (hz && !bus.Flush && mCnt < CNT_MAX) mCnt++;
    end else begin
      mValid = bus.ID_valid;
      mCtrl  = bus.ID_valid ? bus.ID_ctrl : 9'd0;
      mRd1   = readValue(bus.ID_rs, bus.ID_Read_data_1);
      mRd2   = readValue(bus.ID_rt, bus.ID_Read_data_2);
    end
    mPc = bus.ID_PC_plus4; mImm = bus.ID_imm;
    mRs = bus.ID_rs; mRt = bus.ID_rt; mRd = bus.ID_rd;
  endtask

  // One clock: Stall checked mid-cycle, registered outputs just after the edge.
  task automatic applyStimulus();
    bit expStall;
    #2;
    expStall = modelHazard() && !bus.Flush && rstN;
    lastStall = expStall;
    checkOutput("Stall", bus.Stall, expStall);
    @(posedge clk);
    modelUpdate();
    #1;
    checkOutput("EX_valid", bus.EX_valid, mValid);
    checkOutput("EX_ctrl", bus.EX_ctrl, mCtrl);
    checkOutput("EX_PC_plus4", bus.EX_PC_plus4, mPc);
    checkOutput("EX_imm", bus.EX_imm, mImm);
    checkOutput("EX_Read_data_1", bus.EX_Read_data_1, mRd1);
    checkOutput("EX_Read_data_2", bus.EX_Read_data_2, mRd2);
    checkOutput("EX_rs", bus.EX_rs, mRs);
    checkOutput("EX_rt", bus.EX_rt, mRt);
    checkOutput("EX_rd", bus.EX_rd, mRd);
    checkOutput("Bubble_count", bus.Bubble_count, mCnt);
  endtask

  task automatic setInstr(input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                          input bit usesRt, input bit [8:0] ctrl,
                          input bit [31:0] d1, input bit [31:0] d2);
    bus.ID_valid = 1; bus.ID_rs = rs; bus.ID_rt = rt; bus.ID_rd = rd;
    bus.ID_uses_rt = usesRt; bus.ID_ctrl = ctrl;
    bus.ID_Read_data_1 = d1; bus.ID_Read_data_2 = d2;
    bus.ID_PC_plus4 = $urandom; bus.ID_imm = $urandom;
    bus.Flush = 0; bus.WB_RegWrite = 0; bus.WB_Write_register = 0; bus.WB_Write_data = 0;
  endtask

  task automatic randomInputs(input bit holdId);
    if (!holdId) begin
      bus.ID_valid = ($urandom_range(0, 9) < 8);
      bus.ID_rs = 5'($urandom_range(0, 3));
      bus.ID_rt = 5'($urandom_range(0, 3));
      bus.ID_rd = 5'($urandom);
      bus.ID_uses_rt = 1'($urandom);
      bus.ID_ctrl = 9'($urandom);
      bus.ID_PC_plus4 = $urandom; bus.ID_imm = $urandom;
      bus.ID_Read_data_1 = $urandom; bus.ID_Read_data_2 = $urandom;
    end
    bus.Flush = ($urandom_range(0, 9) == 0);
    bus.WB_RegWrite = 1'($urandom);
    bus.WB_Write_register = 5'($urandom_range(0, 3));
    bus.WB_Write_data = $urandom;
  endtask

  initial begin
    rstN = 0;
    lastStall = 0;
    randomInputs(0);
    modelUpdate();

    // Reset with random ID traffic.
    repeat (2) begin
      @(negedge clk); randomInputs(0);
      applyStimulus();
    end
    checkOutput("reset EX_valid", bus.EX_valid, 0);
    checkOutput("reset EX_Read_data_1", bus.EX_Read_data_1, 0);
    checkOutput("reset Bubble_count", bus.Bubble_count, 0);
    rstN = 1;

    // Plain ALU op.
    setInstr(1, 2, 3, 1, CTRL_ADD, 100, 200);
    applyStimulus();
    checkOutput("add rd1", bus.EX_Read_data_1, 100);
    checkOutput("add rd2", bus.EX_Read_data_2, 200);
    checkOutput("add ctrl", bus.EX_ctrl, CTRL_ADD);

    // Load-use: one bubble, then the add goes through.
    setInstr(1, 4, 0, 0, CTRL_LW, 11, 22);
    applyStimulus();
    setInstr(4, 5, 6, 1, CTRL_ADD, 33, 44);
    #1 checkOutput("lu Stall", bus.Stall, 1);
    applyStimulus();
    checkOutput("lu bubble valid", bus.EX_valid, 0);
    checkOutput("lu bubble ctrl", bus.EX_ctrl, 0);
    checkOutput("lu count", bus.Bubble_count, 1);
    #1 checkOutput("lu Stall cleared", bus.Stall, 0);
    applyStimulus();
    checkOutput("lu add valid", bus.EX_valid, 1);
    checkOutput("lu add rs", bus.EX_rs, 4);

    // Same hazard with Flush: no stall, bubble, count unchanged.
    setInstr(1, 4, 0, 0, CTRL_LW, 11, 22);
    applyStimulus();
    setInstr(4, 5, 6, 1, CTRL_ADD, 33, 44);
    bus.Flush = 1;
    #1 checkOutput("flush Stall", bus.Stall, 0);
    applyStimulus();
    checkOutput("flush valid", bus.EX_valid, 0);
    checkOutput("flush count", bus.Bubble_count, 1);

    // Load into r0 never stalls.
    setInstr(0, 0, 0, 0, CTRL_LW, 1, 2);
    applyStimulus();
    setInstr(0, 0, 7, 1, CTRL_ADD, 1, 2);
    #1 checkOutput("r0 Stall", bus.Stall, 0);
    applyStimulus();

    // Writeback bypass; r0 never bypassed.
    setInstr(3, 1, 2, 1, CTRL_ADD, 7, 8);
    bus.WB_RegWrite = 1; bus.WB_Write_register = 3; bus.WB_Write_data = 300;
    applyStimulus();
    checkOutput("wb rd1", bus.EX_Read_data_1, BYPASS ? 300 : 7);
    checkOutput("wb rd2", bus.EX_Read_data_2, 8);
    setInstr(0, 1, 2, 1, CTRL_ADD, 9, 8);
    bus.WB_RegWrite = 1; bus.WB_Write_register = 0; bus.WB_Write_data = 555;
    applyStimulus();
    checkOutput("wb r0 rd1", bus.EX_Read_data_1, 9);

    // Drive the counter to saturation, then one more hazard.
    repeat (CNT_MAX - 1) begin
      setInstr(1, 6, 0, 0, CTRL_LW, 0, 0);
      applyStimulus();
      setInstr(6, 2, 3, 1, CTRL_ADD, 0, 0);
      applyStimulus();
    end
    checkOutput("sat count", bus.Bubble_count, 15);
    setInstr(1, 6, 0, 0, CTRL_LW, 0, 0);
    applyStimulus();
    setInstr(6, 2, 3, 1, CTRL_ADD, 0, 0);
    applyStimulus();
    checkOutput("sat hold", bus.Bubble_count, 15);

    // Randomized traffic; a stalled instruction is re-presented as upstream would.
    for (int i = 0; i < 3000; i++) begin
      randomInputs(lastStall);
      rstN = ($urandom_range(0, 199) != 0);
      applyStimulus();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
